data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, sets the address width of both requester ports and the memory port.
REQ-002 Parameter DATA_W, default 8, sets the data width of both requester ports and the memory port.
REQ-003 Parameter MEM_DEPTH, default 32, gives the number of valid memory words; legal addresses are 0..MEM_DEPTH-1.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 req_a / req_b  input  1  access request from requester A / B; held high until done_x.
REQ-007 we_a / we_b  input  1  1 = write, 0 = read; sampled with the request.
REQ-008 addr_a / addr_b  input  ADDR_W  word address; sampled with the request.
REQ-009 wdata_a / wdata_b  input  DATA_W  write data; sampled with the request.
REQ-010 gnt_a / gnt_b  output  1  high from SETUP through DONE for the port that owns the memory.
REQ-011 done_a / done_b  output  1  one-cycle completion pulse for the owning port.
REQ-012 err_a / err_b  output  1  high with done_x when the address was out of range.
REQ-013 rdata_a / rdata_b  output  DATA_W  registered read result; holds until that port's next completed read.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 mem_addr  output  ADDR_W  address to the data memory.
REQ-016 mem_wdata  output  DATA_W  write data to the data memory.
REQ-017 mem_write  output  1  write strobe; the memory writes on its rising edge.
REQ-018 mem_rdata  input  DATA_W  combinational read data from the memory at mem_addr.

Function
REQ-019 The FSM SHALL have the states IDLE, SETUP, STROBE and DONE.
REQ-020 Arbitration in IDLE: if exactly one req is high, that port wins; if both are high, the port not granted last wins (round-robin); the winner's we/addr/wdata are latched into internal registers.
REQ-021 Legal address (< MEM_DEPTH): IDLE -> SETUP; out-of-range address: IDLE -> DONE with err_x=1, mem_write never asserted, rdata_x unchanged.
REQ-022 SETUP: mem_addr/mem_wdata driven from the latched registers, mem_write=0; write -> STROBE, read -> DONE with rdata_x <= mem_rdata on that edge.
REQ-023 STROBE: mem_write=1 for exactly one cycle, mem_addr/mem_wdata stable; -> DONE.
REQ-024 DONE: mem_write=0, mem_addr held, done_x=1 for one cycle; -> IDLE unconditionally, giving one idle cycle between transactions.
REQ-025 Latency from the edge that samples req in IDLE: read done at +2 cycles, write done at +3 cycles, error done at +1 cycle.
REQ-026 mem_write SHALL be registered and glitch-free, with at most one rising edge per write transaction.
REQ-027 Once latched, a transaction SHALL complete even if req_x drops or addr_x/wdata_x change before done_x.
REQ-028 A request arriving while busy SHALL wait; it is never dropped and never preempts the current transaction.
REQ-029 Only the owning port's gnt/done/err/rdata SHALL change; the other port's outputs stay static.
REQ-030 last_grant SHALL update on every arbitration, including error transactions.

Reset
REQ-031 When reset is asserted, state SHALL go to IDLE immediately; mem_write, gnt_x, done_x, err_x and busy all go to 0; mem_addr, mem_wdata and rdata_x go to 0; last_grant goes to B, so A wins the first tie.
REQ-032 Reset during STROBE SHALL drop mem_write asynchronously; no done_x is issued for the aborted transaction.
REQ-033 After reset deasserts, the first arbitration occurs on the first rising clk edge with a req high.

Verification
REQ-034 Read A: addr_a=5 with mem_rdata=5 -> gnt_a at +1, done_a at +2, rdata_a=0x05, mem_write never high.
REQ-035 Write B: addr_b=20, wdata_b=0xAA -> mem_addr=20 from SETUP through DONE, one-cycle mem_write pulse at +2, done_b at +3.
REQ-036 Tie after reset: req_a and req_b held high, both writes -> order A, B, A, B; each done pulse single-cycle, one idle cycle between transactions.
REQ-037 Out of range: addr_a=32 read -> done_a and err_a at +1, no mem_write edge, rdata_a unchanged.
REQ-038 Reset mid-write: reset asserted while mem_write=1 -> mem_write=0 without waiting for clk, busy=0, no done; the next req_b arbitrates normally.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Each transaction runs IDLE -> SETUP -> (STROBE) -> DONE -> IDLE; out-of-range addresses short-cut to DONE with err.
module data_mem_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              done_a,
    output logic              done_b,
    output logic              err_a,
    output logic              err_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);

    state_t              state_r;
    state_t              next_state_s;
    logic                owner_b_r;
    logic                last_b_r;
    logic                lat_we_r;
    logic                err_pend_r;
    logic                pick_b_s;
    logic                next_owner_b_s;
    logic                next_err_s;
    logic                arb_s;
    logic                legal_s;
    logic                sel_we_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;
    logic                gnt_a_r;
    logic                gnt_b_r;
    logic                done_a_r;
    logic                done_b_r;
    logic                err_a_r;
    logic                err_b_r;
    logic                busy_r;
    logic                mem_write_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic [DATA_W-1:0]   rdata_a_r;
    logic [DATA_W-1:0]   rdata_b_r;

    // Round-robin pick: on a tie the port not granted last time wins.
    always_comb begin
        pick_b_s = 1'b0;
        if (req_a && req_b) begin
            pick_b_s = ~last_b_r;
        end else if (req_b) begin
            pick_b_s = 1'b1;
        end else begin
            pick_b_s = 1'b0;
        end
    end

    assign arb_s       = (state_r == ST_IDLE) && (req_a || req_b);
    assign sel_we_s    = pick_b_s ? we_b    : we_a;
    assign sel_addr_s  = pick_b_s ? addr_b  : addr_a;
    assign sel_wdata_s = pick_b_s ? wdata_b : wdata_a;
    assign legal_s     = ({1'b0, sel_addr_s} < DEPTH_L);

    // Next-state logic, plus the owner/error context the next state will carry.
    always_comb begin
        next_state_s   = state_r;
        next_owner_b_s = owner_b_r;
        next_err_s     = err_pend_r;
        case (state_r)
            ST_IDLE: begin
                if (req_a || req_b) begin
                    next_owner_b_s = pick_b_s;
                    next_err_s     = ~legal_s;
                    next_state_s   = legal_s ? ST_SETUP : ST_DONE;
                end else begin
                    next_state_s   = ST_IDLE;
                end
            end
            ST_SETUP:  next_state_s = lat_we_r ? ST_STROBE : ST_DONE;
            ST_STROBE: next_state_s = ST_DONE;
            ST_DONE:   next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Transaction context latched at arbitration; the memory bus only moves for legal addresses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_b_r   <= 1'b0;
            last_b_r    <= 1'b1;
            lat_we_r    <= 1'b0;
            err_pend_r  <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
        end else if (arb_s) begin
            owner_b_r  <= pick_b_s;
            last_b_r   <= pick_b_s;
            lat_we_r   <= sel_we_s;
            err_pend_r <= ~legal_s;
            if (legal_s) begin
                mem_addr_r  <= sel_addr_s;
                mem_wdata_r <= sel_wdata_s;
            end
        end
    end

    // Registered handshake outputs decoded from the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_a_r     <= 1'b0;
            gnt_b_r     <= 1'b0;
            done_a_r    <= 1'b0;
            done_b_r    <= 1'b0;
            err_a_r     <= 1'b0;
            err_b_r     <= 1'b0;
            busy_r      <= 1'b0;
            mem_write_r <= 1'b0;
        end else begin
            gnt_a_r     <= (next_state_s != ST_IDLE) && !next_owner_b_s;
            gnt_b_r     <= (next_state_s != ST_IDLE) &&  next_owner_b_s;
            done_a_r    <= (next_state_s == ST_DONE) && !next_owner_b_s;
            done_b_r    <= (next_state_s == ST_DONE) &&  next_owner_b_s;
            err_a_r     <= (next_state_s == ST_DONE) && !next_owner_b_s && next_err_s;
            err_b_r     <= (next_state_s == ST_DONE) &&  next_owner_b_s && next_err_s;
            busy_r      <= (next_state_s != ST_IDLE);
            mem_write_r <= (next_state_s == ST_STROBE);
        end
    end

    // Read data is captured on the edge leaving SETUP, into the owner's register only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_a_r <= {DATA_W{1'b0}};
            rdata_b_r <= {DATA_W{1'b0}};
        end else if ((state_r == ST_SETUP) && !lat_we_r) begin
            if (owner_b_r) begin
                rdata_b_r <= mem_rdata;
            end else begin
                rdata_a_r <= mem_rdata;
            end
        end
    end

    assign gnt_a     = gnt_a_r;
    assign gnt_b     = gnt_b_r;
    assign done_a    = done_a_r;
    assign done_b    = done_b_r;
    assign err_a     = err_a_r;
    assign err_b     = err_b_r;
    assign busy      = busy_r;
    assign mem_write = mem_write_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign rdata_a   = rdata_a_r;
    assign rdata_b   = rdata_b_r;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed testbench for data_mem_arbiter with a behavioural 256-word memory preset to mem[i] = i.
module tb_data_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
    logic [7:0] addr_a = 8'd0, wdata_a = 8'd0, addr_b = 8'd0, wdata_b = 8'd0;
    logic       gnt_a, gnt_b, done_a, done_b, err_a, err_b, busy, mem_write;
    logic [7:0] rdata_a, rdata_b, mem_addr, mem_wdata, mem_rdata;
    logic [7:0] mem [0:255];
    logic [7:0] ctl;
    int         total = 0;
    int         bad = 0;
    int         wr_edges = 0;
    int         w0;

    data_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_DEPTH(32)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
        .err_a(err_a), .err_b(err_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
        .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
        end else if (mem_write) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    assign mem_rdata = mem[mem_addr];
    assign ctl = {gnt_a, gnt_b, done_a, done_b, err_a, err_b, busy, mem_write};

    always @(posedge mem_write) wr_edges++;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step();
        step();
        total++; if (ctl !== 8'b0000_0000) begin bad++; $display("FAIL reset_ctl got=%b want=%b", ctl, 8'b0000_0000); end
        total++; if ({mem_addr, mem_wdata, rdata_a, rdata_b} !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=%h", {mem_addr, mem_wdata, rdata_a, rdata_b}, 32'h0); end
        @(negedge clk);
        reset = 1'b0;
        step();
        total++; if (ctl !== 8'b0000_0000) begin bad++; $display("FAIL idle_no_req got=%b want=%b", ctl, 8'b0000_0000); end
    endtask

    task automatic test_read_a;
        w0 = wr_edges;
        req_a = 1'b1; we_a = 1'b0; addr_a = 8'd5;
        step();
        total++; if (ctl !== 8'b1000_0010) begin bad++; $display("FAIL read_a_setup got=%b want=%b", ctl, 8'b1000_0010); end
        total++; if (mem_addr !== 8'd5) begin bad++; $display("FAIL read_a_addr got=%0d want=%0d", mem_addr, 5); end
        addr_a = 8'd9;
        step();
        total++; if (ctl !== 8'b1010_0010) begin bad++; $display("FAIL read_a_done got=%b want=%b", ctl, 8'b1010_0010); end
        total++; if (rdata_a !== 8'h05) begin bad++; $display("FAIL read_a_rdata got=%h want=%h", rdata_a, 8'h05); end
        total++; if (rdata_b !== 8'h00) begin bad++; $display("FAIL read_a_rdata_b got=%h want=%h", rdata_b, 8'h00); end
        req_a = 1'b0;
        step();
        total++; if (ctl !== 8'b0000_0000) begin bad++; $display("FAIL read_a_idle got=%b want=%b", ctl, 8'b0000_0000); end
        total++; if (wr_edges !== w0) begin bad++; $display("FAIL read_a_no_write got=%0d want=%0d", wr_edges, w0); end
    endtask

    task automatic test_write_b;
        w0 = wr_edges;
        req_b = 1'b1; we_b = 1'b1; addr_b = 8'd20; wdata_b = 8'hAA;
        step();
        total++; if (ctl !== 8'b0100_0010) begin bad++; $display("FAIL write_b_setup got=%b want=%b", ctl, 8'b0100_0010); end
        total++; if (mem_addr !== 8'd20) begin bad++; $display("FAIL write_b_addr_setup got=%0d want=%0d", mem_addr, 20); end
        addr_b = 8'd3; wdata_b = 8'h11;
        step();
        total++; if (ctl !== 8'b0100_0011) begin bad++; $display("FAIL write_b_strobe got=%b want=%b", ctl, 8'b0100_0011); end
        total++; if ({mem_addr, mem_wdata} !== {8'd20, 8'hAA}) begin bad++; $display("FAIL write_b_bus got=%h want=%h", {mem_addr, mem_wdata}, {8'd20, 8'hAA}); end
        step();
        total++; if (ctl !== 8'b0101_0010) begin bad++; $display("FAIL write_b_done got=%b want=%b", ctl, 8'b0101_0010); end
        total++; if (mem_addr !== 8'd20) begin bad++; $display("FAIL write_b_addr_done got=%0d want=%0d", mem_addr, 20); end
        total++; if (mem[20] !== 8'hAA) begin bad++; $display("FAIL write_b_mem got=%h want=%h", mem[20], 8'hAA); end
        total++; if (wr_edges !== w0 + 1) begin bad++; $display("FAIL write_b_edges got=%0d want=%0d", wr_edges, w0 + 1); end
        req_b = 1'b0;
        step();
        total++; if (ctl !== 8'b0000_0000) begin bad++; $display("FAIL write_b_idle got=%b want=%b", ctl, 8'b0000_0000); end
        total++; if (rdata_a !== 8'h05) begin bad++; $display("FAIL write_b_rdata_a_static got=%h want=%h", rdata_a, 8'h05); end
    endtask

    task automatic test_out_of_range;
        w0 = wr_edges;
        req_a = 1'b1; we_a = 1'b0; addr_a = 8'd32;
        step();
        total++; if (ctl !== 8'b1010_1010) begin bad++; $display("FAIL oor_a_done got=%b want=%b", ctl, 8'b1010_1010); end
        total++; if (rdata_a !== 8'h05) begin bad++; $display("FAIL oor_a_rdata got=%h want=%h", rdata_a, 8'h05); end
        req_a = 1'b0;
        step();
        total++; if (ctl !== 8'b0000_0000) begin bad++; $display("FAIL oor_a_idle got=%b want=%b", ctl, 8'b0000_0000); end
        req_b = 1'b1; we_b = 1'b1; addr_b = 8'hFF; wdata_b = 8'h00;
        step();
        total++; if (ctl !== 8'b0101_0110) begin bad++; $display("FAIL oor_b_done got=%b want=%b", ctl, 8'b0101_0110); end
        req_b = 1'b0;
        step();
        total++; if (ctl !== 8'b0000_0000) begin bad++; $display("FAIL oor_b_idle got=%b want=%b", ctl, 8'b0000_0000); end
        total++; if (wr_edges !== w0) begin bad++; $display("FAIL oor_no_write got=%0d want=%0d", wr_edges, w0); end
        total++; if (mem[255] !== 8'hFF) begin bad++; $display("FAIL oor_mem got=%h want=%h", mem[255], 8'hFF); end
    endtask

    task automatic test_tie;
        logic [7:0] exp;
        int m;
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        w0 = wr_edges;
        req_a = 1'b1; we_a = 1'b1; addr_a = 8'd1; wdata_a = 8'h11;
        req_b = 1'b1; we_b = 1'b1; addr_b = 8'd2; wdata_b = 8'h22;
        for (int c = 1; c <= 16; c++) begin
            step();
            m = c % 8;
            exp = {(m >= 1 && m <= 3), (m >= 5 && m <= 7), (m == 3), (m == 7),
                   2'b00, ((m % 4) != 0), (m == 2 || m == 6)};
            total++; if (ctl !== exp) begin bad++; $display("FAIL tie_cycle%0d got=%b want=%b", c, ctl, exp); end
        end
        req_a = 1'b0; req_b = 1'b0;
        total++; if ({mem[1], mem[2]} !== 16'h1122) begin bad++; $display("FAIL tie_mem got=%h want=%h", {mem[1], mem[2]}, 16'h1122); end
        total++; if (wr_edges !== w0 + 4) begin bad++; $display("FAIL tie_edges got=%0d want=%0d", wr_edges, w0 + 4); end
        step();
    endtask

    task automatic test_reset_mid_write;
        req_b = 1'b1; we_b = 1'b1; addr_b = 8'd7; wdata_b = 8'h77;
        step();
        step();
        total++; if (ctl !== 8'b0100_0011) begin bad++; $display("FAIL rst_mid_strobe got=%b want=%b", ctl, 8'b0100_0011); end
        #2;
        reset = 1'b1;
        req_b = 1'b0;
        #1;
        total++; if (ctl !== 8'b0000_0000) begin bad++; $display("FAIL rst_mid_async got=%b want=%b", ctl, 8'b0000_0000); end
        step();
        total++; if (ctl !== 8'b0000_0000) begin bad++; $display("FAIL rst_mid_no_done got=%b want=%b", ctl, 8'b0000_0000); end
        total++; if (mem[7] !== 8'h07) begin bad++; $display("FAIL rst_mid_mem got=%h want=%h", mem[7], 8'h07); end
        @(negedge clk) reset = 1'b0;
        req_b = 1'b1; we_b = 1'b0; addr_b = 8'd6;
        step();
        total++; if (ctl !== 8'b0100_0010) begin bad++; $display("FAIL rst_after_setup got=%b want=%b", ctl, 8'b0100_0010); end
        step();
        total++; if (ctl !== 8'b0101_0010) begin bad++; $display("FAIL rst_after_done got=%b want=%b", ctl, 8'b0101_0010); end
        total++; if (rdata_b !== 8'h06) begin bad++; $display("FAIL rst_after_rdata got=%h want=%h", rdata_b, 8'h06); end
        req_b = 1'b0;
        step();
        total++; if (ctl !== 8'b0000_0000) begin bad++; $display("FAIL rst_after_idle got=%b want=%b", ctl, 8'b0000_0000); end
    endtask

    initial begin
        test_reset();
        test_read_a();
        test_write_b();
        test_out_of_range();
        test_tie();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
